ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single RAM port between four requesters: data requesters d0/d1 and instruction requesters i0/i1 (cores 0 and 1).
- Data requests have priority over instruction requests. Within each class, cores are served round-robin.
- A data requester can lock the port across consecutive words for a block transfer.
- Sits between the cache-side request ports and the RAM model; provides timeout and error reporting.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, cycles in OWN without ramstate==ACCESS before a forced release

Ports:
- CLK in 1 — clock, rising edge
- nRST in 1 — asynchronous active-low reset
- dREN in 2 — data read request, bit n = core n
- dWEN in 2 — data write request
- dlock in 2 — hold the grant after this word completes
- daddr in 2*ADDR_W — data addresses, core n at [n*ADDR_W +: ADDR_W]
- dstore in 2*DATA_W — write data, same packing
- iREN in 2 — instruction read request
- iaddr in 2*ADDR_W — instruction addresses
- dwait out 2 — data stall per core
- iwait out 2 — instruction stall per core
- dload out DATA_W — read data to data requesters
- iload out DATA_W — read data to instruction requesters
- ramREN out 1 — RAM read enable
- ramWEN out 1 — RAM write enable
- ramaddr out ADDR_W — RAM address
- ramstore out DATA_W — RAM write data
- ramload in DATA_W — RAM read data
- ramstate in 2 — RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- grant out 4 — one-hot owner, bit order {i1,i0,d1,d0}; 0 when idle
- err out 1 — one-cycle pulse on RAM ERROR or timeout

Behaviour:
- Clock and reset: one clock CLK. Reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, grant=0, drr=0, irr=0, tcnt=0, err=0. ramREN, ramWEN, ramaddr and ramstore are 0 because they decode from grant.
- Reset mid-transfer: all RAM strobes drop immediately, asynchronously.
- States: IDLE and OWN.
- Arbitration (IDLE): a data request is dREN|dWEN for a core. If any data request is present, the winner is core drr when it requests, else the other core. Otherwise the same rule applies to instruction requests with irr. The winner is registered into grant; state becomes OWN. Latency is 1 cycle from request to RAM strobe.
- OWN, RAM drive: ramaddr, ramstore, ramREN and ramWEN are driven combinationally from the granted requester. If dWEN and dREN are both high, dWEN wins and ramREN=0. Instruction grants drive ramREN only.
- dload and iload equal ramload combinationally at all times. They are valid only when the matching wait is low.
- Wait rule: a requester's wait is 1 while it requests and is not (granted AND ramstate==ACCESS). A requester that is not requesting sees wait=0.
- On ramstate==ACCESS:
  - tcnt clears.
  - If the owner is data with dlock set and its request still asserted, stay in OWN with the same grant.
  - Otherwise go to IDLE with grant=0, and set that class's pointer to the other core.
- Abort: if the owner deasserts its request while ramstate!=ACCESS, go to IDLE next edge. Strobes drop combinationally. Pointer unchanged.
- On ramstate==ERROR:
  - Go to IDLE and pulse err for 1 cycle.
  - Owner wait stays 1; the requester may re-request.
  - Pointer rotates.
- Timeout: tcnt increments each OWN cycle without ACCESS. When tcnt==TIMEOUT-1 and still no ACCESS: release to IDLE, pulse err, clear tcnt, rotate pointer.
- Simultaneous events:
  - A new request arriving in the same cycle as a release is arbitrated in IDLE on the following cycle. There is no same-cycle handoff.
  - ACCESS takes precedence over abort and timeout in the same cycle.
- Starvation: with drr rotation, a data requester waits at most one foreign data transfer or lock chain. Instruction requesters starve while data requests are continuous; this is accepted.

Test Plan:
- Single data write: d0 dWEN=1, daddr=0x40, dstore=0xDEAD, ramstate=BUSY for 2 cycles then ACCESS. Required: grant=0001 one cycle after the request; ramWEN=1 with ramaddr=0x40 and ramstore=0xDEAD; dwait[0]=1 until the ACCESS cycle, 0 then; IDLE next; drr=1.
- Priority and round-robin: d0, d1 and i0 all request at once, ACCESS every OWN cycle. Required grant sequence: 0001, idle, 0010, idle, 0001 (d0 re-requesting); i0 granted (0100) only after both data requests drop.
- Lock burst: d1 dREN=1, dlock=1, daddr 0x80 then 0x84, ramload 7 then 9. Required: grant stays 0010 across both ACCESS cycles with no IDLE gap; dload=7 then 9; dwait[1]=0 on each ACCESS; release after dlock=0.
- Errors: owner sees ramstate=ERROR → err=1 for exactly 1 cycle, IDLE next. Owner sees BUSY for 15 cycles → err pulse on cycle 15, grant=0.
- Abort and reset: i1 granted, iREN[1] dropped while BUSY → ramREN=0 immediately, IDLE next edge, irr unchanged. Separately, nRST=0 mid-OWN → grant=0 and ramWEN=0 without a clock edge.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Four-way arbiter for the single RAM port. Data requesters (d0/d1) outrank
// instruction requesters (i0/i1), each class rotates round-robin, a data owner
// may lock the port over consecutive words, and a stalled owner is forced off
// after TIMEOUT cycles with an err pulse.
module ram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [1:0]          dREN,
  input  logic [1:0]          dWEN,
  input  logic [1:0]          dlock,
  input  logic [2*ADDR_W-1:0] daddr,
  input  logic [2*DATA_W-1:0] dstore,
  input  logic [1:0]          iREN,
  input  logic [2*ADDR_W-1:0] iaddr,
  output logic [1:0]          dwait,
  output logic [1:0]          iwait,
  output logic [DATA_W-1:0]   dload,
  output logic [DATA_W-1:0]   iload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [ADDR_W-1:0]   ramaddr,
  output logic [DATA_W-1:0]   ramstore,
  input  logic [DATA_W-1:0]   ramload,
  input  logic [1:0]          ramstate,
  output logic [3:0]          grant,
  output logic                err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state;
  logic          drr;
  logic          irr;
  logic [TW-1:0] tcnt;

  logic [1:0] dreq;
  logic       dgnt;
  logic       ignt;
  logic       dsel;
  logic       isel;
  logic       own_req;
  logic       access;

  // Round-robin pick: the pointed-to core if it requests, otherwise the other.
  function automatic logic pick(input logic [1:0] req, input logic ptr);
    return req[ptr] ? ptr : ~ptr;
  endfunction

  assign dreq    = dREN | dWEN;
  assign dgnt    = |grant[1:0];
  assign ignt    = |grant[3:2];
  assign dsel    = grant[1];
  assign isel    = grant[3];
  assign access  = (ramstate == RS_ACCESS);
  assign own_req = (dgnt & dreq[dsel]) | (ignt & iREN[isel]);

  // A requester stalls until its own granted word sees ACCESS.
  assign dwait[0] = dreq[0] & ~(grant[0] & access);
  assign dwait[1] = dreq[1] & ~(grant[1] & access);
  assign iwait[0] = iREN[0] & ~(grant[2] & access);
  assign iwait[1] = iREN[1] & ~(grant[3] & access);

  assign dload = ramload;
  assign iload = ramload;

  // RAM strobes decode straight from grant so they fall with the request or reset.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (dgnt) begin
      ramaddr  = dsel ? daddr[2*ADDR_W-1:ADDR_W]  : daddr[ADDR_W-1:0];
      ramstore = dsel ? dstore[2*DATA_W-1:DATA_W] : dstore[DATA_W-1:0];
      ramWEN   = dWEN[dsel];
      ramREN   = dREN[dsel] & ~dWEN[dsel];
    end else if (ignt) begin
      ramaddr  = isel ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
      ramREN   = iREN[isel];
    end
  end

  // Arbitration FSM: grant in IDLE, hold/release/abort/error/timeout in OWN.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      grant <= '0;
      drr   <= 1'b0;
      irr   <= 1'b0;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (|dreq) begin
            grant <= pick(dreq, drr) ? 4'b0010 : 4'b0001;
            state <= OWN;
          end else if (|iREN) begin
            grant <= pick(iREN, irr) ? 4'b1000 : 4'b0100;
            state <= OWN;
          end
        end
        OWN: begin
          if (access) begin
            tcnt <= '0;
            if (!(dgnt & dlock[dsel] & dreq[dsel])) begin
              state <= IDLE;
              grant <= '0;
              if (dgnt) drr <= ~dsel;
              else      irr <= ~isel;
            end
          end else if (ramstate == RS_ERROR) begin
            state <= IDLE;
            grant <= '0;
            tcnt  <= '0;
            err   <= 1'b1;
            if (dgnt) drr <= ~dsel;
            else      irr <= ~isel;
          end else if (!own_req) begin
            // Owner walked away: release without touching the pointer.
            state <= IDLE;
            grant <= '0;
            tcnt  <= '0;
          end else if (tcnt == TMAX) begin
            state <= IDLE;
            grant <= '0;
            tcnt  <= '0;
            err   <= 1'b1;
            if (dgnt) drr <= ~dsel;
            else      irr <= ~isel;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed per-cycle vector table, hand-written
// timeout/abort/reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_ram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [1:0]    dREN, dWEN, dlock, iREN, ramstate;
  logic [2*AW-1:0] daddr, iaddr;
  logic [2*DW-1:0] dstore;
  logic [1:0]    dwait, iwait;
  logic [DW-1:0] dload, iload, ramload, ramstore;
  logic          ramREN, ramWEN, err;
  logic [AW-1:0] ramaddr;
  logic [3:0]    grant;

  int n_cmp = 0;
  int n_bad = 0;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .dlock(dlock), .daddr(daddr), .dstore(dstore),
    .iREN(iREN), .iaddr(iaddr),
    .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant(grant), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rst;
    logic [1:0]  dren, dwen, dlk, iren, rs;
    logic [31:0] da1, ld;
    logic [3:0]  g;
    logic        ren, wen;
    logic [31:0] addr;
    logic [1:0]  dw, iw;
    logic        e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input logic [1:0] dren, dwen, dlk, iren, rs,
                             input logic [31:0] da1, ld, input logic [3:0] g,
                             input logic ren, wen, input logic [31:0] addr,
                             input logic [1:0] dw, iw, input logic e);
    vec_t r;
    r.rst = rst; r.dren = dren; r.dwen = dwen; r.dlk = dlk; r.iren = iren; r.rs = rs;
    r.da1 = da1; r.ld = ld; r.g = g; r.ren = ren; r.wen = wen; r.addr = addr;
    r.dw = dw; r.iw = iw; r.e = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state (transaction level: owner index in {d0,d1,i0,i1})
  int          mo;
  int          mptr [2];
  int          mtcnt;
  bit          merr;
  bit          rq [4];
  int          mc, mk, rsel;
  logic [3:0]  e_g;
  logic        e_ren, e_wen;
  logic [31:0] e_addr, e_store, e_st;
  logic [1:0]  e_dw, e_iw;
  vec_t        t;

  initial begin
    dREN = 0; dWEN = 0; dlock = 0; iREN = 0; ramstate = FREE; ramload = 0;
    daddr = {32'h80, 32'h40}; dstore = {32'hBEEF, 32'hDEAD}; iaddr = {32'h104, 32'h100};

    // ---- reset state ----
    #12;
    chk("reset grant", grant, 0);
    chk("reset err", err, 0);
    chk("reset ramREN", ramREN, 0);
    chk("reset ramWEN", ramWEN, 0);
    chk("reset ramaddr", ramaddr, 0);
    chk("reset ramstore", ramstore, 0);
    nRST = 1'b1;

    // ---- directed vector table (one row per clock cycle) ----
    //                 rst dren dwen dlk iren rs    da1    ld  g  ren wen addr    dw iw e
    // single write by d0, two BUSY cycles then ACCESS
    tbl.push_back(v(0, 0, 1, 0, 0, BUSY, 'h80, 0, 0, 0, 0, 'h00,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, BUSY, 'h80, 0, 1, 0, 1, 'h40,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, BUSY, 'h80, 0, 1, 0, 1, 'h40,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, ACC,  'h80, 0, 1, 0, 1, 'h40,  0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, FREE, 'h80, 0, 0, 0, 0, 'h00,  0, 0, 0));
    // priority and round-robin: d0, d1, i0 together, ACCESS every cycle
    tbl.push_back(v(1, 3, 0, 0, 1, ACC,  'h80, 0, 0, 0, 0, 'h00,  3, 1, 0));
    tbl.push_back(v(0, 3, 0, 0, 1, ACC,  'h80, 0, 1, 1, 0, 'h40,  2, 1, 0));
    tbl.push_back(v(0, 3, 0, 0, 1, ACC,  'h80, 0, 0, 0, 0, 'h00,  3, 1, 0));
    tbl.push_back(v(0, 3, 0, 0, 1, ACC,  'h80, 0, 2, 1, 0, 'h80,  1, 1, 0));
    tbl.push_back(v(0, 3, 0, 0, 1, ACC,  'h80, 0, 0, 0, 0, 'h00,  3, 1, 0));
    tbl.push_back(v(0, 3, 0, 0, 1, ACC,  'h80, 0, 1, 1, 0, 'h40,  2, 1, 0));
    tbl.push_back(v(0, 2, 0, 0, 1, ACC,  'h80, 0, 0, 0, 0, 'h00,  2, 1, 0));
    tbl.push_back(v(0, 2, 0, 0, 1, ACC,  'h80, 0, 2, 1, 0, 'h80,  0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, ACC,  'h80, 0, 0, 0, 0, 'h00,  0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, ACC,  'h80, 0, 4, 1, 0, 'h100, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, FREE, 'h80, 0, 0, 0, 0, 'h00,  0, 0, 0));
    // locked burst by d1: two words, lock dropped on the second
    tbl.push_back(v(0, 2, 0, 2, 0, BUSY, 'h80, 0, 0, 0, 0, 'h00,  2, 0, 0));
    tbl.push_back(v(0, 2, 0, 2, 0, ACC,  'h80, 7, 2, 1, 0, 'h80,  0, 0, 0));
    tbl.push_back(v(0, 2, 0, 0, 0, ACC,  'h84, 9, 2, 1, 0, 'h84,  0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, FREE, 'h80, 0, 0, 0, 0, 'h00,  0, 0, 0));
    // RAM error on a d0 write
    tbl.push_back(v(0, 0, 1, 0, 0, BUSY, 'h80, 0, 0, 0, 0, 'h00,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, ERR,  'h80, 0, 1, 0, 1, 'h40,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, FREE, 'h80, 0, 0, 0, 0, 'h00,  0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, FREE, 'h80, 0, 0, 0, 0, 'h00,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(posedge CLK);
      #1;
      if (t.rst) begin
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
      end else begin
        #1;
      end
      dREN = t.dren; dWEN = t.dwen; dlock = t.dlk; iREN = t.iren;
      ramstate = t.rs; ramload = t.ld;
      daddr = {t.da1, 32'h40};
      #2;
      e_st = (t.g == 4'b0001) ? 32'hDEAD : (t.g == 4'b0010) ? 32'hBEEF : 32'h0;
      chk($sformatf("row%0d grant", i), grant, t.g);
      chk($sformatf("row%0d ramREN", i), ramREN, t.ren);
      chk($sformatf("row%0d ramWEN", i), ramWEN, t.wen);
      chk($sformatf("row%0d ramaddr", i), ramaddr, t.addr);
      chk($sformatf("row%0d ramstore", i), ramstore, e_st);
      chk($sformatf("row%0d dwait", i), dwait, t.dw);
      chk($sformatf("row%0d iwait", i), iwait, t.iw);
      chk($sformatf("row%0d err", i), err, t.e);
      chk($sformatf("row%0d dload", i), dload, t.ld);
    end

    // ---- timeout: i1 held in BUSY ----
    tick(); iREN = 2'b10; ramstate = BUSY; #3;
    chk("to request grant", grant, 0);
    for (int k = 0; k < TO; k++) begin
      tick(); #3;
      chk($sformatf("to own%0d grant", k), grant, 4'b1000);
      chk($sformatf("to own%0d err", k), err, 0);
    end
    tick(); iREN = 0; #3;
    chk("to release grant", grant, 0);
    chk("to release err", err, 1);
    tick(); #3;
    chk("to err pulse end", err, 0);

    // ---- abort: i0 transfer first so irr points at i1, then i1 aborts ----
    tick(); iREN = 2'b01; ramstate = ACC; #3;
    tick(); #3;
    chk("ab i0 grant", grant, 4'b0100);
    tick(); iREN = 2'b10; ramstate = BUSY; #3;
    tick(); #3;
    chk("ab i1 grant", grant, 4'b1000);
    chk("ab i1 ramREN", ramREN, 1);
    chk("ab i1 ramaddr", ramaddr, 32'h104);
    iREN = 0; #1;
    chk("ab drop ramREN", ramREN, 0);
    chk("ab drop iwait", iwait, 0);
    tick(); #3;
    chk("ab idle grant", grant, 0);
    tick(); iREN = 2'b11; #3;
    tick(); #3;
    chk("ab irr kept grant", grant, 4'b1000);
    iREN = 0;
    tick(); #3;
    chk("ab second abort grant", grant, 0);

    // ---- asynchronous reset in OWN ----
    tick(); dWEN = 2'b01; ramstate = BUSY; #3;
    tick(); #3;
    chk("rst own grant", grant, 4'b0001);
    chk("rst own ramWEN", ramWEN, 1);
    nRST = 1'b0; #1;
    chk("rst async grant", grant, 0);
    chk("rst async ramWEN", ramWEN, 0);
    chk("rst async ramaddr", ramaddr, 0);
    nRST = 1'b1; dWEN = 0; ramstate = FREE;

    // ---- randomized traffic against the reference model ----
    mo = -1; mptr[0] = 0; mptr[1] = 0; mtcnt = 0; merr = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      dREN = 2'($urandom); dWEN = 2'($urandom); dlock = 2'($urandom); iREN = 2'($urandom);
      daddr = {$urandom, $urandom}; dstore = {$urandom, $urandom};
      iaddr = {$urandom, $urandom}; ramload = $urandom;
      rsel = $urandom_range(0, 19);
      ramstate = (rsel < 8) ? ACC : (rsel < 16) ? BUSY : (rsel < 17) ? ERR : FREE;
      #3;
      rq[0] = dREN[0] | dWEN[0]; rq[1] = dREN[1] | dWEN[1];
      rq[2] = iREN[0];           rq[3] = iREN[1];
      e_g = (mo < 0) ? 4'b0 : (4'b1 << mo);
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
      if (mo == 0 || mo == 1) begin
        e_addr  = daddr[mo*32 +: 32];
        e_store = dstore[mo*32 +: 32];
        e_wen   = dWEN[mo];
        e_ren   = dREN[mo] & ~dWEN[mo];
      end else if (mo >= 2) begin
        e_addr = iaddr[(mo-2)*32 +: 32];
        e_ren  = iREN[mo-2];
      end
      for (int r = 0; r < 4; r++) begin
        if (r < 2) e_dw[r]   = rq[r] && !(mo == r && ramstate == ACC);
        else       e_iw[r-2] = rq[r] && !(mo == r && ramstate == ACC);
      end
      chk($sformatf("rnd%0d grant", c), grant, e_g);
      chk($sformatf("rnd%0d ramREN", c), ramREN, e_ren);
      chk($sformatf("rnd%0d ramWEN", c), ramWEN, e_wen);
      chk($sformatf("rnd%0d ramaddr", c), ramaddr, e_addr);
      chk($sformatf("rnd%0d ramstore", c), ramstore, e_store);
      chk($sformatf("rnd%0d dwait", c), dwait, e_dw);
      chk($sformatf("rnd%0d iwait", c), iwait, e_iw);
      chk($sformatf("rnd%0d err", c), err, merr);
      chk($sformatf("rnd%0d iload", c), iload, ramload);
      // advance the model to the next clock edge
      merr = 0;
      if (mo < 0) begin
        mtcnt = 0;
        mc = (rq[0] || rq[1]) ? 0 : (rq[2] || rq[3]) ? 1 : -1;
        if (mc >= 0) begin
          mk = rq[mc*2 + mptr[mc]] ? mptr[mc] : 1 - mptr[mc];
          mo = mc*2 + mk;
        end
      end else begin
        mc = mo / 2;
        mk = mo % 2;
        if (ramstate == ACC) begin
          mtcnt = 0;
          if (!(mc == 0 && dlock[mk] && rq[mo])) begin
            mptr[mc] = 1 - mk;
            mo = -1;
          end
        end else if (ramstate == ERR) begin
          merr = 1; mptr[mc] = 1 - mk; mo = -1; mtcnt = 0;
        end else if (!rq[mo]) begin
          mo = -1; mtcnt = 0;
        end else if (mtcnt == TO - 1) begin
          merr = 1; mptr[mc] = 1 - mk; mo = -1; mtcnt = 0;
        end else begin
          mtcnt++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
